seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit BCD 7-segment driver: shadow register, refresh divider,
// leading-zero suppression, blanking, sticky invalid-code flag, output polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_MAX     = 49999,
  parameter int ACTIVE_LOW  = 0,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    code_err
);

  localparam int   DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    load_err;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic                    cur_sup;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   en_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  assign tick = (div_cnt == DIV_W'(DIV_MAX));

  always_comb begin
    load_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) load_err = 1'b1;
    end
  end

  // A digit is blanked when it and every more significant digit are zero;
  // digit 0 always shows so an all-zero value reads "0".
  always_comb begin
    logic run_zero;
    run_zero = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero    = run_zero & (shadow_bcd[4*i +: 4] == 4'd0);
      suppress[i] = run_zero && (i != 0) && (LZ_SUPPRESS != 0);
    end
  end

  always_comb begin
    cur_bcd = 4'd0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    en_nxt  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_bcd   = shadow_bcd[4*i +: 4];
        cur_dp    = shadow_dp[i];
        cur_sup   = suppress[i];
        en_nxt[i] = 1'b1;
      end
    end
    seg_nxt = (blank || cur_sup) ? 7'b0000000 : decode(cur_bcd);
    dp_nxt  = blank ? 1'b0 : cur_dp;
    if (blank) en_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      idx        <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      code_err   <= 1'b0;
      seg        <= {7{POL}};
      dp         <= POL;
      digit_en   <= {NUM_DIGITS{POL}};
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (load) begin
        shadow_bcd <= bcd_in;
        shadow_dp  <= dp_in;
        code_err   <= load_err;
      end
      // Polarity is applied last, after blanking and suppression.
      seg      <= seg_nxt ^ {7{POL}};
      dp       <= dp_nxt ^ POL;
      digit_en <= en_nxt ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (active-high and
// active-low) share stimulus; expected segment codes are hand-computed.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset, load, blank;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg, seg_al;
  logic        dp, dp_al, err, err_al;
  logic [3:0]  en, en_al;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .DIV_MAX(3), .ACTIVE_LOW(0), .LZ_SUPPRESS(1)) dut (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank(blank), .seg(seg), .dp(dp), .digit_en(en), .code_err(err)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .DIV_MAX(3), .ACTIVE_LOW(1), .LZ_SUPPRESS(1)) dut_al (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank(blank), .seg(seg_al), .dp(dp_al), .digit_en(en_al), .code_err(err_al)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; bcd_in = v; dp_in = d;
    step();
    load = 1'b0;
  endtask

  // Step until digit k has just become active (first sample of that digit).
  task automatic wait_first(input int k, input string tag);
    logic [3:0] target, prev;
    bit found;
    found  = 1'b0;
    target = 4'(1 << k);
    prev   = en;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (en == target && prev != target) found = 1'b1;
      prev = en;
    end
    check({tag, "_align"}, 32'(found), 32'd1);
  endtask

  // Called on the first sample of digit k; checks both polarities, then
  // counts how long the digit stays active and leaves on the next digit.
  task automatic scan_digit(input int k, input logic [6:0] exp_seg, input logic exp_dp,
                            input string tag);
    logic [3:0] target, inv_en;
    logic [6:0] inv_seg;
    logic       inv_dp;
    int         hold;
    bit         done;
    target  = 4'(1 << k);
    inv_en  = ~target;
    inv_seg = ~exp_seg;
    inv_dp  = ~exp_dp;
    check($sformatf("%s_d%0d_en", tag, k), 32'(en), 32'(target));
    check($sformatf("%s_d%0d_seg", tag, k), 32'(seg), 32'(exp_seg));
    check($sformatf("%s_d%0d_dp", tag, k), 32'(dp), 32'(exp_dp));
    check($sformatf("%s_d%0d_en_al", tag, k), 32'(en_al), 32'(inv_en));
    check($sformatf("%s_d%0d_seg_al", tag, k), 32'(seg_al), 32'(inv_seg));
    check($sformatf("%s_d%0d_dp_al", tag, k), 32'(dp_al), 32'(inv_dp));
    hold = 1;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      step();
      if (en == target) hold++;
      else done = 1'b1;
    end
    check($sformatf("%s_d%0d_hold", tag, k), 32'(hold), 32'd4);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; blank = 1'b0; bcd_in = '0; dp_in = '0;
    repeat (3) step();
    check("rst_en", 32'(en), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_en_al", 32'(en_al), 32'hF);
    check("rst_seg_al", 32'(seg_al), 32'h7F);
    check("rst_dp_al", 32'(dp_al), 32'h1);

    // Scan of 1234: first output sample still shows the old (zero) shadow.
    reset = 1'b0;
    do_load(16'h1234, 4'b0000);
    check("ld_lat_en", 32'(en), 32'h1);
    check("ld_lat_seg", 32'(seg), 32'(7'b0111111));
    step();
    check("t1_d0_seg", 32'(seg), 32'(7'b1100110));
    check("t1_err", 32'(err), 32'h0);
    wait_first(1, "t1");
    scan_digit(1, 7'b1001111, 1'b0, "t1");
    scan_digit(2, 7'b1011011, 1'b0, "t1");
    scan_digit(3, 7'b0000110, 1'b0, "t1");
    scan_digit(0, 7'b1100110, 1'b0, "t1");

    // Blank for 10 cycles starting with div=1, idx=1; divider keeps running.
    blank = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      check($sformatf("blk_en_%0d", n), 32'(en), 32'h0);
      check($sformatf("blk_seg_%0d", n), 32'(seg), 32'h0);
    end
    check("blk_dp", 32'(dp), 32'h0);
    blank = 1'b0;
    step();
    check("blk_rel_en", 32'(en), 32'h8);
    check("blk_rel_seg", 32'(seg), 32'(7'b0000110));
    step();
    check("blk_rel2_en", 32'(en), 32'h1);
    check("blk_rel2_seg", 32'(seg), 32'(7'b1100110));

    // Leading-zero suppression.
    do_load(16'h0070, 4'b0000);
    wait_first(0, "lz70");
    scan_digit(0, 7'b0111111, 1'b0, "lz70");
    scan_digit(1, 7'b0000111, 1'b0, "lz70");
    scan_digit(2, 7'b0000000, 1'b0, "lz70");
    scan_digit(3, 7'b0000000, 1'b0, "lz70");
    do_load(16'h0000, 4'b0000);
    wait_first(0, "lz00");
    scan_digit(0, 7'b0111111, 1'b0, "lz00");
    scan_digit(1, 7'b0000000, 1'b0, "lz00");
    scan_digit(2, 7'b0000000, 1'b0, "lz00");
    scan_digit(3, 7'b0000000, 1'b0, "lz00");

    // Invalid code and sticky error flag.
    check("err_pre", 32'(err), 32'h0);
    do_load(16'h9A05, 4'b0000);
    check("err_set", 32'(err), 32'h1);
    check("err_set_al", 32'(err_al), 32'h1);
    wait_first(0, "bad");
    scan_digit(0, 7'b1101101, 1'b0, "bad");
    scan_digit(1, 7'b0111111, 1'b0, "bad");
    scan_digit(2, 7'b1000000, 1'b0, "bad");
    scan_digit(3, 7'b1101111, 1'b0, "bad");
    check("err_hold", 32'(err), 32'h1);
    do_load(16'h0005, 4'b0000);
    check("err_clr", 32'(err), 32'h0);

    // Decimal point and active-low outputs.
    do_load(16'h0008, 4'b0001);
    wait_first(0, "dp8");
    scan_digit(0, 7'b1111111, 1'b1, "dp8");
    scan_digit(1, 7'b0000000, 1'b0, "dp8");

    // Reset with load during digit 2; reset wins and the scan restarts.
    wait_first(2, "mrst");
    step();
    reset = 1'b1; load = 1'b1; bcd_in = 16'hFFFF; dp_in = 4'hF;
    step();
    check("mrst_en", 32'(en), 32'h0);
    check("mrst_seg", 32'(seg), 32'h0);
    check("mrst_dp", 32'(dp), 32'h0);
    check("mrst_err", 32'(err), 32'h0);
    check("mrst_en_al", 32'(en_al), 32'hF);
    check("mrst_seg_al", 32'(seg_al), 32'h7F);
    reset = 1'b0; load = 1'b0;
    step();
    scan_digit(0, 7'b0111111, 1'b0, "mrst");
    scan_digit(1, 7'b0000000, 1'b0, "mrst");
    check("mrst_err_after", 32'(err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
